// File: rtl/emissor_rpn_pkg.sv
// Shared definitions for the RPN token emitter: FSM encoding, token types and sizes.
package emissor_rpn_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        EMITE_NUM = 3'd1,
        EMITE_OP  = 3'd2,
        EXECUTA   = 3'd3,
        ERRO      = 3'd4
    } estado_t;

    localparam logic NUMERO   = 1'b0;
    localparam logic OPERACAO = 1'b1;

    localparam int FIFO_PROF = 4;
    localparam int CAP_PILHA = 2;

endpackage

// File: rtl/emissor_rpn_fila_tokens.sv
// Four-entry token FIFO ({tipo,dado}) with level count and synchronous flush.
module fila_tokens
    import emissor_rpn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       limpar,
    input  logic       escrever,
    input  logic       ler,
    input  logic [8:0] dado_in,
    output logic [8:0] dado_out,
    output logic [2:0] nivel,
    output logic       pronto,
    output logic       vazia
);

    logic [8:0] mem [FIFO_PROF];
    logic [1:0] ptr_esc;
    logic [1:0] ptr_lei;
    logic       aceita;
    logic       retira;

    assign pronto   = (nivel != 3'(FIFO_PROF));
    assign vazia    = (nivel == 3'd0);
    assign aceita   = escrever && pronto;
    assign retira   = ler && !vazia;
    assign dado_out = mem[ptr_lei];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_esc <= '0;
            ptr_lei <= '0;
            nivel   <= '0;
        end else if (limpar) begin
            ptr_esc <= '0;
            ptr_lei <= '0;
            nivel   <= '0;
        end else begin
            if (aceita) ptr_esc <= ptr_esc + 2'd1;
            if (retira) ptr_lei <= ptr_lei + 2'd1;
            if (aceita && !retira)
                nivel <= nivel + 3'd1;
            else if (retira && !aceita)
                nivel <= nivel - 3'd1;
        end
    end

    // Storage needs no reset: the level count gates every read.
    always_ff @(posedge clk) begin
        if (aceita && !limpar)
            mem[ptr_esc] <= dado_in;
    end

endmodule

// File: rtl/emissor_rpn.sv
// Turns a stream of RPN tokens into push/select/execute strobes for a 2-deep stack,
// tracking stack depth and flagging overflow/underflow.
//
// state     | meaning
// OCIOSO    | idle; pops the FIFO head when one is present
// EMITE_NUM | entrada_numero strobe, depth grows on exit
// EMITE_OP  | entrada_operacao strobe
// EXECUTA   | executar strobe, depth shrinks on exit
// ERRO      | sticky error; waits for limpar or rst
module emissor_rpn
    import emissor_rpn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tok_valido,
    output logic       tok_pronto,
    input  logic       tok_tipo,
    input  logic [7:0] tok_dado,
    input  logic       limpar,
    output logic [7:0] entrada,
    output logic [2:0] operacao,
    output logic       entrada_numero,
    output logic       entrada_operacao,
    output logic       executar,
    output logic [1:0] profundidade,
    output logic [2:0] fifo_nivel,
    output logic       ocupado,
    output logic       erro_estouro,
    output logic       erro_falta
);

    estado_t    estado;
    logic [8:0] cabeca;
    logic       vazia;
    logic       retirar;

    assign retirar = (estado == OCIOSO) && !vazia && !limpar;

    fila_tokens u_fila (
        .clk      (clk),
        .rst      (rst),
        .limpar   (limpar),
        .escrever (tok_valido),
        .ler      (retirar),
        .dado_in  ({tok_tipo, tok_dado}),
        .dado_out (cabeca),
        .nivel    (fifo_nivel),
        .pronto   (tok_pronto),
        .vazia    (vazia)
    );

    // Strobes decode the state register directly, so at most one is ever high.
    assign entrada_numero   = (estado == EMITE_NUM);
    assign entrada_operacao = (estado == EMITE_OP);
    assign executar         = (estado == EXECUTA);
    assign ocupado          = (estado != OCIOSO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado       <= OCIOSO;
            profundidade <= '0;
            entrada      <= '0;
            operacao     <= '0;
            erro_estouro <= 1'b0;
            erro_falta   <= 1'b0;
        end else if (limpar) begin
            estado       <= OCIOSO;
            profundidade <= '0;
            erro_estouro <= 1'b0;
            erro_falta   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (!vazia) begin
                        if (cabeca[8] == NUMERO) begin
                            if (profundidade < 2'(CAP_PILHA)) begin
                                entrada <= cabeca[7:0];
                                estado  <= EMITE_NUM;
                            end else begin
                                erro_estouro <= 1'b1;
                                estado       <= ERRO;
                            end
                        end else begin
                            if (profundidade == 2'(CAP_PILHA)) begin
                                operacao <= cabeca[2:0];
                                estado   <= EMITE_OP;
                            end else begin
                                erro_falta <= 1'b1;
                                estado     <= ERRO;
                            end
                        end
                    end
                end
                EMITE_NUM: begin
                    profundidade <= profundidade + 2'd1;
                    estado       <= OCIOSO;
                end
                EMITE_OP: estado <= EXECUTA;
                EXECUTA: begin
                    profundidade <= profundidade - 2'd1;
                    estado       <= OCIOSO;
                end
                ERRO:    estado <= ERRO;
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule
